// File: rtl/iram_arb_pkg.sv
// Shared constants and types for the IRAM port arbiter.
package iram_arb_pkg;

    localparam int unsigned N_CORES = 4;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CID_W   = $clog2(N_CORES);

    // Read-return tag travelling alongside the RAM read latency.
    typedef struct packed {
        logic             valid;
        logic [CID_W-1:0] cid;
    } tag_t;

    localparam int unsigned TAG_W = $bits(tag_t);

endpackage

// File: rtl/iram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible core at or after ptr wins.
module rr_pick
    import iram_arb_pkg::*;
(
    input  logic [N_CORES-1:0] elig,
    input  logic [CID_W-1:0]   ptr,
    output logic [N_CORES-1:0] win_oh_c,
    output logic [CID_W-1:0]   win_idx_c,
    output logic               any_c
);

    logic [CID_W-1:0] idx;

    // Scan ptr, ptr+1, ... ; N_CORES is a power of two so CID_W wrap gives the modulo.
    always_comb begin
        win_oh_c  = '0;
        win_idx_c = '0;
        any_c     = 1'b0;
        idx       = '0;
        for (int i = 0; i < N_CORES; i++) begin
            idx = ptr + CID_W'(i);
            if (!any_c && elig[idx]) begin
                any_c          = 1'b1;
                win_idx_c      = idx;
                win_oh_c[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iram_port_arbiter.sv
// Round-robin arbiter sharing one single-port IRAM between the array cores.
module iram_port_arbiter
    import iram_arb_pkg::*;
#(
    parameter int unsigned RAM_LAT = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_CORES-1:0]        i_req_rd,
    input  logic [N_CORES-1:0]        i_req_wr,
    input  logic [N_CORES*ADDR_W-1:0] i_addr,
    input  logic [N_CORES*DATA_W-1:0] i_wdata,
    output logic [N_CORES-1:0]        o_gnt,
    output logic [N_CORES-1:0]        o_rvalid,
    output logic [DATA_W-1:0]         o_rdata,
    output logic [ADDR_W-1:0]         o_ram_addr,
    output logic [DATA_W-1:0]         o_ram_data,
    output logic                      o_ram_rden,
    output logic                      o_ram_wren,
    input  logic [DATA_W-1:0]         i_ram_q
);

    logic [N_CORES-1:0] elig_c;
    logic [N_CORES-1:0] win_oh_c;
    logic [CID_W-1:0]   win_idx_c;
    logic               any_c;
    logic [CID_W-1:0]   ptr_q;
    logic [CID_W-1:0]   cid_q;
    tag_t               tag_q [RAM_LAT];
    tag_t               tag_end;

    // A core granted this cycle is masked so its still-held request is not granted twice.
    assign elig_c  = (i_req_rd | i_req_wr) & ~o_gnt;
    assign tag_end = tag_q[RAM_LAT-1];

    rr_pick u_pick (
        .elig      (elig_c),
        .ptr       (ptr_q),
        .win_oh_c  (win_oh_c),
        .win_idx_c (win_idx_c),
        .any_c     (any_c)
    );

    // Grant and IRAM port registers; a combined rd+wr request performs only the write.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_gnt      <= '0;
            o_ram_addr <= '0;
            o_ram_data <= '0;
            o_ram_rden <= 1'b0;
            o_ram_wren <= 1'b0;
            ptr_q      <= '0;
            cid_q      <= '0;
        end else begin
            o_gnt      <= win_oh_c;
            o_ram_wren <= any_c & i_req_wr[win_idx_c];
            o_ram_rden <= any_c & i_req_rd[win_idx_c] & ~i_req_wr[win_idx_c];
            cid_q      <= win_idx_c;
            if (any_c) begin
                o_ram_addr <= i_addr[32'(win_idx_c)*ADDR_W +: ADDR_W];
                o_ram_data <= i_wdata[32'(win_idx_c)*DATA_W +: DATA_W];
                ptr_q      <= win_idx_c + CID_W'(1);
            end
        end
    end

    // Tag pipeline follows the registered read enable through the RAM latency.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < RAM_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= {o_ram_rden, cid_q};
            for (int i = 1; i < RAM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Read return: one-hot valid to the issuing core, data captured from the RAM.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rvalid <= '0;
            o_rdata  <= '0;
        end else begin
            o_rvalid <= N_CORES'(tag_end.valid) << tag_end.cid;
            if (tag_end.valid) begin
                o_rdata <= i_ram_q;
            end
        end
    end

endmodule

// File: tb/tb_iram_port_arbiter.sv
// Scoreboard bench: three arbiters (RAM_LAT 1..3) share one stimulus stream.
module tb_iram_port_arbiter;
    import iram_arb_pkg::*;

    localparam int unsigned N_LAT = 3;

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    typedef struct packed {
        logic [3:0] oh;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [N_CORES-1:0]        req_rd;
    logic [N_CORES-1:0]        req_wr;
    logic [N_CORES*ADDR_W-1:0] addr_bus;
    logic [N_CORES*DATA_W-1:0] wdata_bus;

    logic [N_CORES-1:0] gnt      [N_LAT];
    logic [N_CORES-1:0] rvalid   [N_LAT];
    logic [DATA_W-1:0]  rdata    [N_LAT];
    logic [ADDR_W-1:0]  ram_addr [N_LAT];
    logic [DATA_W-1:0]  ram_data [N_LAT];
    logic [DATA_W-1:0]  ram_q    [N_LAT];
    logic               rden     [N_LAT];
    logic               wren     [N_LAT];

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    txn_t       cq    [N_CORES][$];
    exp_t       exp_q [N_LAT][$];
    logic [3:0] gnt_log [$];
    int         gnt_cyc [$];
    logic [7:0] shadow [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_LAT; g++) begin : g_lat
        logic [7:0] mem  [256];
        logic [7:0] pipe [g+1];

        iram_port_arbiter #(.RAM_LAT(g + 1)) u_dut (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_req_rd   (req_rd),
            .i_req_wr   (req_wr),
            .i_addr     (addr_bus),
            .i_wdata    (wdata_bus),
            .o_gnt      (gnt[g]),
            .o_rvalid   (rvalid[g]),
            .o_rdata    (rdata[g]),
            .o_ram_addr (ram_addr[g]),
            .o_ram_data (ram_data[g]),
            .o_ram_rden (rden[g]),
            .o_ram_wren (wren[g]),
            .i_ram_q    (ram_q[g])
        );

        initial begin
            for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'hB5;
        end

        // IRAM model: read sampled on the edge, data out after g+1 edges.
        always @(posedge clk) begin
            if (rden[g]) pipe[0] <= mem[ram_addr[g]];
            for (int i = 1; i <= g; i++) pipe[i] <= pipe[i-1];
            if (wren[g]) mem[ram_addr[g]] = ram_data[g];
        end

        assign ram_q[g] = pipe[g];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [3:0] log_at(input int i);
        if (i < gnt_log.size()) return gnt_log[i];
        return 4'hF;
    endfunction

    task automatic drive();
        for (int k = 0; k < N_CORES; k++) begin
            if (cq[k].size() > 0) begin
                req_rd[k] = cq[k][0].rd;
                req_wr[k] = cq[k][0].wr;
                addr_bus[k*ADDR_W +: ADDR_W]  = cq[k][0].addr;
                wdata_bus[k*DATA_W +: DATA_W] = cq[k][0].data;
            end else begin
                req_rd[k] = 1'b0;
                req_wr[k] = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        txn_t       t;
        exp_t       e;
        logic [3:0] rv_exp;
        int         k;
        for (int g = 0; g < N_LAT; g++) begin
            rv_exp = 4'b0;
            if (exp_q[g].size() > 0 && exp_q[g][0].due == cyc) begin
                e      = exp_q[g].pop_front();
                rv_exp = e.oh;
                check($sformatf("rdata_lat%0d", g + 1), 32'(rdata[g]), 32'(e.data));
            end
            check($sformatf("rvalid_lat%0d", g + 1), 32'(rvalid[g]), 32'(rv_exp));
            if (g > 0) check($sformatf("gnt_match_lat%0d", g + 1), 32'(gnt[g]), 32'(gnt[0]));
        end
        if (gnt[0] != 4'b0) begin
            check("gnt_onehot", 32'($countones(gnt[0])), 32'd1);
            k = 0;
            for (int i = 0; i < N_CORES; i++) if (gnt[0][i]) k = i;
            if (cq[k].size() == 0) begin
                check("gnt_spurious", 32'(gnt[0]), 32'd0);
            end else begin
                t = cq[k].pop_front();
                check("ram_addr", 32'(ram_addr[0]), 32'(t.addr));
                check("ram_wren", 32'(wren[0]), 32'(t.wr));
                check("ram_rden", 32'(rden[0]), 32'(t.rd & ~t.wr));
                if (t.wr) begin
                    check("ram_data", 32'(ram_data[0]), 32'(t.data));
                    shadow[t.addr] = t.data;
                end else begin
                    for (int g = 0; g < N_LAT; g++)
                        exp_q[g].push_back('{oh: gnt[0], data: shadow[t.addr], due: cyc + g + 2});
                end
                gnt_log.push_back(gnt[0]);
                gnt_cyc.push_back(cyc);
            end
        end else begin
            check("idle_en", 32'({rden[0], wren[0]}), 32'd0);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        monitor();
        drive();
    endtask

    task automatic clear_log();
        gnt_log.delete();
        gnt_cyc.delete();
    endtask

    task automatic wait_grants(input int n, input int budget, input string tag);
        int b = 0;
        while (gnt_log.size() < n && b < budget) begin
            step();
            b++;
        end
        check(tag, 32'(gnt_log.size()), 32'(n));
    endtask

    task automatic drain(input int budget);
        int b = 0;
        int pend;
        pend = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
        while (pend != 0 && b < budget) begin
            step();
            b++;
            pend = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
        end
        check("drain", 32'(pend), 32'd0);
        repeat (3) step();
    endtask

    task automatic check_idle(input string tag);
        for (int g = 0; g < N_LAT; g++) begin
            check({tag, "_gnt"},    32'(gnt[g]),      32'd0);
            check({tag, "_rvalid"}, 32'(rvalid[g]),   32'd0);
            check({tag, "_rdata"},  32'(rdata[g]),    32'd0);
            check({tag, "_addr"},   32'(ram_addr[g]), 32'd0);
            check({tag, "_wdata"},  32'(ram_data[g]), 32'd0);
            check({tag, "_en"},     32'({rden[g], wren[g]}), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int a = 0; a < 256; a++) shadow[a] = 8'(a) ^ 8'hB5;
        rst       = 1'b1;
        req_rd    = '0;
        req_wr    = '0;
        addr_bus  = '0;
        wdata_bus = '0;
        @(negedge clk);
        check_idle("reset");
        step();
        step();
        rst = 1'b0;

        // Four cores reading continuously: strict rotation, no idle cycles.
        clear_log();
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < N_CORES; k++)
                cq[k].push_back('{rd: 1'b1, wr: 1'b0, addr: 8'(4 * j + k), data: 8'h00});
        drive();
        wait_grants(12, 40, "rr_grants");
        for (int i = 0; i < 12; i++) begin
            check($sformatf("rr_order%0d", i), 32'(log_at(i)), 32'(1) << (i % 4));
            if (i < gnt_cyc.size())
                check($sformatf("rr_gap%0d", i), 32'(gnt_cyc[i] - gnt_cyc[0]), 32'(i));
        end
        drain(20);

        // Single read from core 2 of address 0x10.
        clear_log();
        cq[2].push_back('{rd: 1'b1, wr: 1'b0, addr: 8'h10, data: 8'h00});
        drive();
        wait_grants(1, 10, "single_grant");
        check("single_gnt", 32'(log_at(0)), 32'b0100);
        drain(10);

        // Core 1 writes 0x3C to 0x20, then core 3 reads it back.
        clear_log();
        cq[1].push_back('{rd: 1'b0, wr: 1'b1, addr: 8'h20, data: 8'h3C});
        drive();
        wait_grants(1, 10, "wr_grant");
        repeat (3) step();
        cq[3].push_back('{rd: 1'b1, wr: 1'b0, addr: 8'h20, data: 8'h00});
        drive();
        wait_grants(2, 10, "rd_after_wr");
        check("wr_order0", 32'(log_at(0)), 32'b0010);
        check("wr_order1", 32'(log_at(1)), 32'b1000);
        drain(10);

        // Core 0 asserts read and write together: one grant, write wins.
        clear_log();
        cq[0].push_back('{rd: 1'b1, wr: 1'b1, addr: 8'h05, data: 8'h77});
        drive();
        wait_grants(1, 10, "rw_grant");
        repeat (4) step();
        check("rw_single", 32'(gnt_log.size()), 32'd1);
        check("rw_gnt", 32'(log_at(0)), 32'b0001);
        cq[0].push_back('{rd: 1'b1, wr: 1'b0, addr: 8'h05, data: 8'h00});
        drive();
        wait_grants(2, 10, "rw_readback");
        drain(10);

        // Reset while reads from cores 0 and 1 are in flight.
        clear_log();
        cq[0].push_back('{rd: 1'b1, wr: 1'b0, addr: 8'h30, data: 8'h00});
        cq[1].push_back('{rd: 1'b1, wr: 1'b0, addr: 8'h31, data: 8'h00});
        drive();
        wait_grants(2, 10, "pre_rst_grants");
        cq[1].push_back('{rd: 1'b1, wr: 1'b0, addr: 8'h32, data: 8'h00});
        cq[3].push_back('{rd: 1'b1, wr: 1'b0, addr: 8'h33, data: 8'h00});
        drive();
        rst = 1'b1;
        #1;
        check_idle("mid_rst");
        for (int g = 0; g < N_LAT; g++) exp_q[g].delete();
        step();
        step();
        rst = 1'b0;
        clear_log();
        wait_grants(2, 10, "post_rst_grants");
        check("post_rst0", 32'(log_at(0)), 32'b0010);
        check("post_rst1", 32'(log_at(1)), 32'b1000);
        repeat (6) step();
        drain(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
